// File: rtl/cpu_control_unit_if.sv
// Control-unit bus: instruction/flag inputs from memory and ALU, and the
// decode, register-file strobe and PC outputs driven by the control unit.
interface cpu_control_unit_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic [31:0]         INSTRUCTION;
  logic                ZERO;
  logic [PC_WIDTH-1:0] PC;
  logic [2:0]          READREG1;
  logic [2:0]          READREG2;
  logic [2:0]          WRITEREG;
  logic                WRITEENABLE;
  logic [7:0]          IMMEDIATE;
  logic                IMM_SEL;
  logic                NEG_SEL;
  logic [2:0]          ALUOP;
  logic                ERROR;

  modport master (
    input  INSTRUCTION, ZERO,
    output PC, READREG1, READREG2, WRITEREG, WRITEENABLE,
           IMMEDIATE, IMM_SEL, NEG_SEL, ALUOP, ERROR
  );

  modport slave (
    output INSTRUCTION, ZERO,
    input  PC, READREG1, READREG2, WRITEREG, WRITEENABLE,
           IMMEDIATE, IMM_SEL, NEG_SEL, ALUOP, ERROR
  );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle FETCH/EXECUTE/WRITEBACK controller and program counter for the
// 8-bit CPU; halts with a sticky ERROR on an illegal opcode.
module cpu_control_unit #(
  parameter int unsigned              PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]      RESET_PC    = '0,
  parameter int unsigned              EXEC_CYCLES = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  cpu_control_unit_if.master  bus
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  typedef enum logic [7:0] {
    OP_LOADI = 8'h00,
    OP_MOV   = 8'h01,
    OP_ADD   = 8'h02,
    OP_SUB   = 8'h03,
    OP_AND   = 8'h04,
    OP_OR    = 8'h05,
    OP_J     = 8'h06,
    OP_BEQ   = 8'h07
  } opcode_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [31:0]         r_ir;
  logic [3:0]          r_cnt;
  logic                r_taken;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_error;

  opcode_t             w_opcode;
  logic                w_legal;
  logic                w_write;
  logic                w_jump;
  logic                w_beq;
  logic                w_imm_sel;
  logic                w_neg_sel;
  logic [2:0]          w_alu_op;
  logic                w_active;
  logic [PC_WIDTH-1:0] w_offset;
  logic [PC_WIDTH-1:0] w_pc_seq;
  logic                w_unused;

  assign w_opcode = opcode_t'(r_ir[31:24]);
  assign w_unused = ^r_ir[15:11] ^ ^r_ir[7:3];

  always_comb begin
    w_legal   = 1'b1;
    w_write   = 1'b0;
    w_jump    = 1'b0;
    w_beq     = 1'b0;
    w_imm_sel = 1'b0;
    w_neg_sel = 1'b0;
    w_alu_op  = 3'b000;
    case (w_opcode)
      OP_LOADI: begin w_write = 1'b1; w_imm_sel = 1'b1; end
      OP_MOV:   w_write = 1'b1;
      OP_ADD:   begin w_write = 1'b1; w_alu_op = 3'b001; end
      OP_SUB:   begin w_write = 1'b1; w_alu_op = 3'b001; w_neg_sel = 1'b1; end
      OP_AND:   begin w_write = 1'b1; w_alu_op = 3'b010; end
      OP_OR:    begin w_write = 1'b1; w_alu_op = 3'b011; end
      OP_J:     w_jump = 1'b1;
      OP_BEQ:   begin w_beq = 1'b1; w_alu_op = 3'b001; w_neg_sel = 1'b1; end
      default:  w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:     w_next_state = S_EXECUTE;
      S_EXECUTE: begin
        if (!w_legal)
          w_next_state = S_HALT;
        else if (r_cnt == 4'd0)
          w_next_state = S_WRITEBACK;
      end
      S_WRITEBACK: w_next_state = S_FETCH;
      S_HALT:      w_next_state = S_HALT;
      default:     w_next_state = S_FETCH;
    endcase
  end

  // Branch offset is a signed word count relative to the following instruction.
  assign w_offset = PC_WIDTH'($signed(r_ir[23:16])) << 2;
  assign w_pc_seq = r_pc + PC_WIDTH'(4);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_cnt   <= '0;
      r_taken <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_FETCH: begin
          r_ir  <= bus.INSTRUCTION;
          r_cnt <= 4'(EXEC_CYCLES - 1);
        end
        S_EXECUTE: begin
          if (!w_legal)
            r_error <= 1'b1;
          if (r_cnt != 4'd0)
            r_cnt <= r_cnt - 4'd1;
          else
            r_taken <= bus.ZERO & w_beq;
        end
        S_WRITEBACK: begin
          if (w_jump || (w_beq && r_taken))
            r_pc <= w_pc_seq + w_offset;
          else
            r_pc <= w_pc_seq;
        end
        default: ;
      endcase
    end
  end

  assign w_active = (r_state == S_EXECUTE) || (r_state == S_WRITEBACK);

  assign bus.PC          = r_pc;
  assign bus.ERROR       = r_error;
  assign bus.WRITEENABLE = (r_state == S_WRITEBACK) && w_write && !RESET;
  assign bus.READREG1    = w_active ? r_ir[10:8]  : '0;
  assign bus.READREG2    = w_active ? r_ir[2:0]   : '0;
  assign bus.WRITEREG    = w_active ? r_ir[18:16] : '0;
  assign bus.IMMEDIATE   = w_active ? r_ir[7:0]   : '0;
  assign bus.IMM_SEL     = w_active & w_imm_sel;
  assign bus.NEG_SEL     = w_active & w_neg_sel;
  assign bus.ALUOP       = w_active ? w_alu_op : '0;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: directed scenarios plus a random instruction
// stream checked cycle by cycle against an instruction-level model.
module tb_cpu_control_unit;

  localparam int unsigned E = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc;
  logic        m_err;

  cpu_control_unit_if #(.PC_WIDTH(32)) bus ();

  cpu_control_unit #(
    .PC_WIDTH   (32),
    .RESET_PC   (32'h0),
    .EXEC_CYCLES(E)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected decode bundle: {rr1, rr2, wr, imm, imm_sel, neg_sel, aluop}
  function automatic logic [21:0] exp_dec(input logic [31:0] ins);
    logic [7:0] op;
    logic [2:0] alu;
    op = ins[31:24];
    if (op == 8'h02 || op == 8'h03 || op == 8'h07) alu = 3'b001;
    else if (op == 8'h04)                          alu = 3'b010;
    else if (op == 8'h05)                          alu = 3'b011;
    else                                           alu = 3'b000;
    return {ins[10:8], ins[2:0], ins[18:16], ins[7:0],
            op == 8'h00, (op == 8'h03 || op == 8'h07), alu};
  endfunction

  function automatic logic [21:0] dut_dec();
    return {bus.READREG1, bus.READREG2, bus.WRITEREG, bus.IMMEDIATE,
            bus.IMM_SEL, bus.NEG_SEL, bus.ALUOP};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One legal instruction from FETCH to the next FETCH; optional reset in WRITEBACK.
  task automatic run_instr(input logic [31:0] ins, input bit z, input bit rst_wb);
    logic [7:0] op;
    bit         taken;
    int         off;
    op = ins[31:24];
    bus.INSTRUCTION = ins;
    bus.ZERO = 1'($urandom);
    @(negedge clk);
    check_eq("fetch_dec", 32'(dut_dec()), 32'h0);
    check_eq("fetch_we", 32'(bus.WRITEENABLE), 32'h0);
    check_eq("fetch_pc", bus.PC, m_pc);
    check_eq("fetch_err", 32'(bus.ERROR), 32'(m_err));
    step();
    bus.INSTRUCTION = $urandom;
    for (int k = 0; k < int'(E); k++) begin
      bus.ZERO = (k == int'(E) - 1) ? z : 1'($urandom);
      @(negedge clk);
      check_eq("exec_dec", 32'(dut_dec()), 32'(exp_dec(ins)));
      check_eq("exec_we", 32'(bus.WRITEENABLE), 32'h0);
      check_eq("exec_pc", bus.PC, m_pc);
      step();
    end
    bus.ZERO = 1'($urandom);
    if (rst_wb) rst = 1'b1;
    @(negedge clk);
    check_eq("wb_dec", 32'(dut_dec()), 32'(exp_dec(ins)));
    check_eq("wb_we", 32'(bus.WRITEENABLE), (!rst_wb && op <= 8'h05) ? 32'h1 : 32'h0);
    check_eq("wb_pc", bus.PC, m_pc);
    step();
    if (rst_wb) begin
      rst   = 1'b0;
      m_pc  = 32'h0;
      m_err = 1'b0;
    end else begin
      taken = (op == 8'h06) || (op == 8'h07 && z);
      off   = taken ? int'($signed(ins[23:16])) * 4 : 0;
      m_pc  = m_pc + 32'(4 + off);
    end
  endtask

  task automatic jump_to(input logic [31:0] target);
    int d;
    d = int'(target - m_pc - 32'd4);
    run_instr({8'h06, 8'(d / 4), 16'h0}, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    @(negedge clk);
    check_eq("rst_we", 32'(bus.WRITEENABLE), 32'h0);
    check_eq("rst_pc", bus.PC, 32'h0);
    check_eq("rst_err", 32'(bus.ERROR), 32'h0);
    check_eq("rst_dec", 32'(dut_dec()), 32'h0);
    step();
    rst   = 1'b0;
    m_pc  = 32'h0;
    m_err = 1'b0;
  endtask

  task automatic run_illegal(input logic [31:0] ins);
    bus.INSTRUCTION = ins;
    @(negedge clk);
    check_eq("ill_fetch_pc", bus.PC, m_pc);
    step();
    bus.INSTRUCTION = $urandom;
    @(negedge clk);
    check_eq("ill_exec_err", 32'(bus.ERROR), 32'h0);
    check_eq("ill_exec_we", 32'(bus.WRITEENABLE), 32'h0);
    step();
    m_err = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.INSTRUCTION = $urandom;
      bus.ZERO = 1'($urandom);
      @(negedge clk);
      check_eq("halt_err", 32'(bus.ERROR), 32'(m_err));
      check_eq("halt_we", 32'(bus.WRITEENABLE), 32'h0);
      check_eq("halt_pc", bus.PC, m_pc);
      check_eq("halt_dec", 32'(dut_dec()), 32'h0);
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  op;
    logic [31:0] ins;
    rst = 1'b1;
    bus.INSTRUCTION = 32'h0;
    bus.ZERO = 1'b0;
    m_pc  = 32'h0;
    m_err = 1'b0;
    step();
    do_reset();

    run_instr(32'h0003002A, 1'b0, 1'b0);
    run_instr(32'h03010205, 1'b0, 1'b0);

    jump_to(32'h10);
    run_instr(32'h07FE0102, 1'b1, 1'b0);
    check_eq("beq_taken_pc", m_pc, 32'h0C);
    jump_to(32'h10);
    run_instr(32'h07FE0102, 1'b0, 1'b0);

    do_reset();
    jump_to(32'hFFFFFFF0);
    run_instr(32'h067F0000, 1'b0, 1'b0);
    run_instr(32'h06800000, 1'b0, 1'b0);

    for (int n = 0; n < 120; n++) begin
      op  = 8'($urandom_range(0, 7));
      ins = {op, 8'($urandom), 8'($urandom), 8'($urandom)};
      run_instr(ins, 1'($urandom), 1'b0);
    end

    do_reset();
    jump_to(32'h40);
    run_instr(32'h02030102, 1'b0, 1'b1);
    run_instr(32'h00050011, 1'b0, 1'b0);

    do_reset();
    jump_to(32'h08);
    run_illegal({8'h09, 24'($urandom)});
    do_reset();
    run_illegal({8'($urandom_range(8, 255)), 24'($urandom)});
    do_reset();
    run_instr(32'h00010001, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("final_pc", bus.PC, m_pc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
